tt_um_karthik_serial_subtractor: RTL and testbench

Bit-serial subtractor, the sequential counterpart of the team's combinational half adder, in the same Tiny Tapeout top-level wrapper. It accepts operands A and B one bit per valid cycle, LSB first. It computes A−B mod 2^WIDTH through a registered borrow chain. It returns each difference bit and borrow on uo_out and presents the completed word in parallel on uio_out.

---
 rtl/tt_um_karthik_serial_subtractor.sv | 124 ++++++++++++
 tb/tb_tt_um_karthik_serial_subtractor.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/tt_um_karthik_serial_subtractor.sv
// Bit-serial subtractor (A-B mod 2^WIDTH, LSB first) with registered borrow chain, Tiny Tapeout wrapper.
// Optional SERIAL_ADD_MODE_EN: ui_in[4] sampled with start selects serial add (1) or subtract (0) per word.
module tt_um_karthik_serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic             diff_q;
  logic             borrow_q;
  logic             done_q;
  logic             busy_q;
  logic             result_valid;
  logic [3:0]       count;
  logic [WIDTH-1:0] shreg;
  logic [7:0]       result;
`ifdef SERIAL_ADD_MODE_EN
  logic             mode_q;
`endif

  logic             a_bit;
  logic             b_bit;
  logic             start;
  logic             bit_vld;
  logic             accept;
  logic             bin;
  logic             mode_cur;
  logic             d;
  logic             bout;
  logic             last;
  logic [3:0]       bit_idx;
  logic [3:0]       new_count;
  logic [WIDTH-1:0] next_word;

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:4]};

  assign a_bit   = ui_in[0];
  assign b_bit   = ui_in[1];
  assign start   = ui_in[2];
  assign bit_vld = ui_in[3];

  // A start bit always begins a fresh word: bin forced to 0 and partial bits dropped.
  always_comb begin
    accept    = bit_vld && (start || (state == SHIFT));
    bin       = start ? 1'b0 : borrow_q;
    bit_idx   = start ? 4'd0 : count;
    new_count = bit_idx + 4'd1;
    last      = (new_count == 4'(WIDTH));
`ifdef SERIAL_ADD_MODE_EN
    mode_cur  = start ? ui_in[4] : mode_q;
`else
    mode_cur  = 1'b0;
`endif
    d = a_bit ^ b_bit ^ bin;
    if (mode_cur)
      bout = (a_bit & b_bit) | (bin & (a_bit ^ b_bit));
    else
      bout = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bin);
    next_word = start ? '0 : shreg;
    for (int i = 0; i < WIDTH; i++) begin
      if (bit_idx == 4'(i)) next_word[i] = d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      diff_q       <= 1'b0;
      borrow_q     <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      count        <= 4'd0;
      shreg        <= '0;
      result       <= 8'h00;
      result_valid <= 1'b0;
`ifdef SERIAL_ADD_MODE_EN
      mode_q       <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      busy_q <= 1'b0;
      if (accept) begin
        diff_q   <= d;
        borrow_q <= bout;
        count    <= new_count;
        shreg    <= next_word;
`ifdef SERIAL_ADD_MODE_EN
        mode_q   <= mode_cur;
`endif
        if (last) begin
          state        <= DONE;
          done_q       <= 1'b1;
          result       <= 8'(next_word);
          result_valid <= 1'b1;
        end else begin
          state  <= SHIFT;
          busy_q <= 1'b1;
        end
      end else if (state == SHIFT) begin
        // Gap in the bit stream: everything holds.
        busy_q <= 1'b1;
      end else begin
        state <= IDLE;
        count <= 4'd0;
      end
    end
  end

  assign uo_out  = {count, busy_q, done_q, borrow_q, diff_q};
  assign uio_out = result;
  assign uio_oe  = {8{result_valid}};

endmodule

// File: tb/tb_tt_um_karthik_serial_subtractor.sv
// Scoreboard bench: expected words queued by stimulus, popped by a monitor on each done pulse.
module tb_tt_um_karthik_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_prev_cyc = 0;
  int done_last_cyc = 0;
  logic [8:0] exp_q[$];   // {final borrow/carry, result}

  tt_um_karthik_serial_subtractor #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && uo_out[2] === 1'b1) begin
      done_cnt++;
      done_prev_cyc = done_last_cyc;
      done_last_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(uio_out), 32'hDEAD);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("result_word", 32'(uio_out), 32'(e[7:0]));
        check("final_borrow", 32'(uo_out[1]), 32'(e[8]));
        check("oe_on_done", 32'(uio_oe), 32'hFF);
        check("count_on_done", 32'(uo_out[7:4]), 32'd8);
        check("busy_on_done", 32'(uo_out[3]), 32'd0);
      end
    end
  end

  task automatic send_bits(input logic [7:0] a, input logic [7:0] b, input int lo, input int n,
                           input logic mode);
    for (int i = lo; i < n; i++) begin
      ui_in = {3'b000, mode, 1'b1, (i == 0), b[i], a[i]};
      @(posedge clk);
      #1;
    end
    ui_in = 8'h00;
  endtask

  task automatic drain;
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int d0;
    logic [7:0] t2_stream;
    ena    = 1'b1;
    uio_in = 8'h00;
    ui_in  = 8'h00;
    rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_uo_out", 32'(uo_out), 32'h00);
    check("reset_uio_out", 32'(uio_out), 32'h00);
    check("reset_uio_oe", 32'(uio_oe), 32'h00);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Valid bit without start in IDLE is ignored.
    ui_in = 8'h09;
    @(posedge clk); #1;
    ui_in = 8'h00;
    check("idle_ignore_count", 32'(uo_out[7:4]), 32'd0);
    check("idle_ignore_busy", 32'(uo_out[3]), 32'd0);

    // 1: 0x5A - 0x3C = 0x1E
    exp_q.push_back({1'b0, 8'h1E});
    send_bits(8'h5A, 8'h3C, 0, 8, 1'b0);
    check("t1_done_latency", 32'(uo_out[2]), 32'd1);
    drain();
    check("t1_idle_count", 32'(uo_out[7:4]), 32'd0);
    check("t1_done_single", 32'(uo_out[2]), 32'd0);

    // 2: 0x10 - 0x20 = 0xF0, borrow out; per-bit diff stream
    exp_q.push_back({1'b1, 8'hF0});
    t2_stream = 8'b1111_0000;
    for (int i = 0; i < 8; i++) begin
      ui_in = {4'b0000, 1'b1, (i == 0), logic'(8'h20 >> i), logic'(8'h10 >> i)};
      @(posedge clk); #1;
      check($sformatf("t2_diff_bit%0d", i), 32'(uo_out[0]), 32'(t2_stream[i]));
      check($sformatf("t2_count%0d", i), 32'(uo_out[7:4]), 32'(i + 1));
    end
    ui_in = 8'h00;
    drain();

    // 3: gap of 3 cycles between bits 3 and 4
    exp_q.push_back({1'b0, 8'h1E});
    send_bits(8'h5A, 8'h3C, 0, 4, 1'b0);
    for (int g = 0; g < 3; g++) begin
      @(posedge clk); #1;
      check("t3_gap_busy", 32'(uo_out[3]), 32'd1);
      check("t3_gap_count", 32'(uo_out[7:4]), 32'd4);
    end
    send_bits(8'h5A, 8'h3C, 4, 8, 1'b0);
    drain();

    // 4: abort after 5 bits, then two back-to-back words
    d0 = done_cnt;
    send_bits(8'hFF, 8'h00, 0, 5, 1'b0);
    check("t4_result_held", 32'(uio_out), 32'h1E);
    exp_q.push_back({1'b1, 8'hFF});
    exp_q.push_back({1'b0, 8'h7F});
    send_bits(8'h01, 8'h02, 0, 8, 1'b0);
    send_bits(8'h80, 8'h01, 0, 8, 1'b0);
    drain();
    check("t4_done_pulses", 32'(done_cnt - d0), 32'd2);
    check("t4_b2b_spacing", 32'(done_last_cyc - done_prev_cyc), 32'd8);

    // 5: reset mid-word
    d0 = done_cnt;
    send_bits(8'h5A, 8'h3C, 0, 4, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("t5_rst_uo_out", 32'(uo_out), 32'h00);
    check("t5_rst_uio_out", 32'(uio_out), 32'h00);
    check("t5_rst_uio_oe", 32'(uio_oe), 32'h00);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("t5_no_done", 32'(done_cnt - d0), 32'd0);
    exp_q.push_back({1'b0, 8'h1E});
    send_bits(8'h5A, 8'h3C, 0, 8, 1'b0);
    drain();

    // 6: mode bit set, A=0xFF B=0x01
`ifdef SERIAL_ADD_MODE_EN
    exp_q.push_back({1'b1, 8'h00});
`else
    exp_q.push_back({1'b0, 8'hFE});
`endif
    send_bits(8'hFF, 8'h01, 0, 8, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
